// File: rtl/biquad_pkg.sv
// Shared constants and FSM state type for the biquad coefficient loader.
// Address map: b0, b1, b2, a1, a2 at 0-4.
package biquad_pkg;

  localparam int NUM_COEF = 5;

  localparam int ADDR_B0 = 0;
  localparam int ADDR_B1 = 1;
  localparam int ADDR_B2 = 2;
  localparam int ADDR_A1 = 3;
  localparam int ADDR_A2 = 4;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } state_t;

endpackage

// File: rtl/biquad_coef_bank.sv
// Five-entry coefficient register bank with single-entry write and bulk load.
// Bulk load takes priority over the single-entry write.
module biquad_coef_bank
  import biquad_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [W-1:0]          i_wdata,
  input  logic                  i_load,
  input  logic [NUM_COEF*W-1:0] i_ldata,
  output logic [NUM_COEF*W-1:0] o_data
);

  logic [W-1:0] r_mem [NUM_COEF];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_COEF; i++)
        r_mem[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < NUM_COEF; i++)
        r_mem[i] <= i_ldata[i*W +: W];
    end else if (i_we) begin
      for (int i = 0; i < NUM_COEF; i++)
        if (32'(i_waddr) == i)
          r_mem[i] <= i_wdata;
    end
  end

  always_comb begin
    o_data = '0;
    for (int i = 0; i < NUM_COEF; i++)
      o_data[i*W +: W] = r_mem[i];
  end

endmodule

// File: rtl/biquad_coef_loader.sv
// Double-buffered biquad coefficient loader: writes go to a shadow bank,
// a commit swaps them into the active bank on the next sample tick.
// Optional readback of the shadow bank: define BIQUAD_COEF_READBACK_EN.
module biquad_coef_loader
  import biquad_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          commit,
  input  logic          sample_tick,
  output logic [W-1:0]  b0,
  output logic [W-1:0]  b1,
  output logic [W-1:0]  b2,
  output logic [W-1:0]  a1,
  output logic [W-1:0]  a2,
  output logic          busy,
`ifdef BIQUAD_COEF_READBACK_EN
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
`endif
  output logic          err
);

  state_t r_state;
  state_t w_next;

  logic w_swap;
  logic w_acc;
  logic w_addr_ok;
  logic w_we;
  logic r_err;

  logic [NUM_COEF*W-1:0] w_shadow;
  logic [NUM_COEF*W-1:0] w_active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    wr_ready = 1'b0;
    busy     = 1'b0;
    w_swap   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (commit) w_next = ST_PENDING;
      end
      ST_PENDING: begin
        busy = 1'b1;
        if (sample_tick) begin
          w_swap = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_acc     = wr_valid & wr_ready;
  assign w_addr_ok = 32'(wr_addr) < NUM_COEF;
  assign w_we      = w_acc & w_addr_ok;

  // Sticky until reset: flags any accepted write outside the map.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err <= 1'b0;
    else if (w_acc && !w_addr_ok) r_err <= 1'b1;
  end

  assign err = r_err;

  biquad_coef_bank #(.W(W), .AW(AW)) u_shadow (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_load  (1'b0),
    .i_ldata ('0),
    .o_data  (w_shadow)
  );

  biquad_coef_bank #(.W(W), .AW(AW)) u_active (
    .clk     (clk),
    .reset   (reset),
    .i_we    (1'b0),
    .i_waddr ('0),
    .i_wdata ('0),
    .i_load  (w_swap),
    .i_ldata (w_shadow),
    .o_data  (w_active)
  );

  assign b0 = w_active[ADDR_B0*W +: W];
  assign b1 = w_active[ADDR_B1*W +: W];
  assign b2 = w_active[ADDR_B2*W +: W];
  assign a1 = w_active[ADDR_A1*W +: W];
  assign a2 = w_active[ADDR_A2*W +: W];

`ifdef BIQUAD_COEF_READBACK_EN
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_COEF; i++)
      if (32'(rd_addr) == i)
        rd_data = w_shadow[i*W +: W];
  end
`endif

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Scoreboard bench for biquad_coef_loader: a driver pushes expected
// post-edge state, a monitor pops and compares after each rising edge.
module tb_biquad_coef_loader;

  localparam int W  = 16;
  localparam int AW = 3;
  localparam int N  = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          commit;
  logic          sample_tick;
  logic [W-1:0]  b0, b1, b2, a1, a2;
  logic          busy;
  logic          err;
`ifdef BIQUAD_COEF_READBACK_EN
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
`endif

  always #5 clk = ~clk;

  biquad_coef_loader #(.W(W), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .sample_tick (sample_tick),
    .b0          (b0),
    .b1          (b1),
    .b2          (b2),
    .a1          (a1),
    .a2          (a2),
    .busy        (busy),
`ifdef BIQUAD_COEF_READBACK_EN
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
`endif
    .err         (err)
  );

  typedef struct {
    logic [N*W-1:0] coef;
    logic           rdy;
    logic           bsy;
    logic           er;
    logic [W-1:0]   rd;
  } exp_t;

  exp_t q[$];
  exp_t me;

  logic [W-1:0] m_sh [N];
  logic [W-1:0] m_ac [N];
  bit           m_pend;
  bit           m_err;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [N*W-1:0] act,
                     input logic [N*W-1:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, want);
    end
  endtask

  task automatic step(input logic v, input int a, input logic [W-1:0] d,
                      input logic c, input logic t, input logic rst);
    exp_t e;
    bit   p0;
    @(negedge clk);
    wr_valid    = v;
    wr_addr     = AW'(a);
    wr_data     = d;
    commit      = c;
    sample_tick = t;
    reset       = rst;
`ifdef BIQUAD_COEF_READBACK_EN
    rd_addr     = AW'($urandom_range(0, 7));
`endif
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_sh[i] = '0;
        m_ac[i] = '0;
      end
      m_pend = 0;
      m_err  = 0;
    end else begin
      p0 = m_pend;
      if (v && !p0) begin
        if (a < N) m_sh[a] = d;
        else       m_err   = 1;
      end
      if (p0 && t) begin
        for (int i = 0; i < N; i++) m_ac[i] = m_sh[i];
        m_pend = 0;
      end else if (!p0 && c) begin
        m_pend = 1;
      end
    end
    for (int i = 0; i < N; i++) e.coef[i*W +: W] = m_ac[i];
    e.rdy = !m_pend;
    e.bsy = m_pend;
    e.er  = m_err;
    e.rd  = '0;
`ifdef BIQUAD_COEF_READBACK_EN
    if (int'(rd_addr) < N) e.rd = m_sh[int'(rd_addr)];
`endif
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("coef",  {a2, a1, b2, b1, b0}, me.coef);
      chk("ready", N*W'(wr_ready), N*W'(me.rdy));
      chk("busy",  N*W'(busy), N*W'(me.bsy));
      chk("err",   N*W'(err), N*W'(me.er));
`ifdef BIQUAD_COEF_READBACK_EN
      chk("rd_data", N*W'(rd_data), N*W'(me.rd));
`endif
    end
  end

  initial begin
    reset       = 1'b0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    commit      = 1'b0;
    sample_tick = 1'b0;
`ifdef BIQUAD_COEF_READBACK_EN
    rd_addr     = '0;
`endif
    for (int i = 0; i < N; i++) begin
      m_sh[i] = '0;
      m_ac[i] = '0;
    end

    // Reset held, then released.
    repeat (3) step(0, 0, '0, 0, 0, 0);
    idle(2);

    // Staged commit with tick three cycles after commit.
    step(1, 0, 16'h0040, 0, 0, 1);
    step(1, 3, 16'hFFC0, 0, 0, 1);
    step(0, 0, '0, 1, 0, 1);
    idle(2);
    step(0, 0, '0, 0, 1, 1);
    idle(2);

    // Write and commit in the same cycle.
    step(1, 2, 16'h1234, 1, 0, 1);
    idle(1);
    step(0, 0, '0, 0, 1, 1);
    idle(1);

    // Backpressure while pending, write lands after the swap.
    step(0, 0, '0, 1, 0, 1);
    step(1, 0, 16'h7FFF, 0, 0, 1);
    step(1, 0, 16'h7FFF, 1, 0, 1);
    step(1, 0, 16'h7FFF, 0, 1, 1);
    step(1, 0, 16'h7FFF, 0, 0, 1);
    step(0, 0, '0, 1, 1, 1);
    step(0, 0, '0, 0, 1, 1);
    idle(1);

    // Invalid address sets sticky err.
    step(1, 6, 16'hAAAA, 0, 0, 1);
    idle(1);
    step(0, 0, '0, 1, 0, 1);
    step(0, 0, '0, 0, 1, 1);
    idle(2);

    // Reset while a commit is pending.
    step(1, 1, 16'h5555, 1, 0, 1);
    idle(1);
    step(0, 0, '0, 0, 0, 0);
    step(0, 0, '0, 0, 1, 1);
    idle(2);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      step(logic'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)),
           W'($urandom),
           logic'($urandom_range(0, 5) == 0),
           logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 60) != 0));
    end
    idle(2);

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
